pal_tape_loader: RTL and testbench

- Hardware loader sitting directly upstream of the PDP-8 memory write port.
- Consumes a PAL binary-format ("pal -o") byte stream and decodes leader, origin, data, checksum and trailer frames.
- Issues memory word writes with address auto-increment, then reports completion and the start PC to the CPU front panel logic.
- Replaces the switch/Deposit/Load_PC loading path for fast program load.

---
 rtl/pal_tape_loader_pkg.sv | 18 +
 rtl/pal_frame_assembler.sv | 71 +++++++
 rtl/pal_tape_loader.sv | 200 ++++++++++++++++++++
 tb/tb_pal_tape_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pal_tape_loader_pkg.sv
// Shared types and constants for the PAL binary tape loader.
package pal_tape_loader_pkg;

   typedef enum logic [2:0] {
      LEADER,
      HIGH,
      LOW,
      COMMIT,
      WRITE,
      FINISH,
      DONE,
      ERROR
   } loader_state_t;

   localparam logic [7:0] LEADER_BYTE = 8'o200;
   localparam int         ORIGIN_BIT  = 6;

endpackage

// File: rtl/pal_frame_assembler.sv
// Pairs tape frames into 12-bit words, flags origin/format conditions and keeps
// the running 12-bit byte sum used for the tape checksum.
module pal_frame_assembler
   import pal_tape_loader_pkg::*;
#(
   parameter int         WORD_W     = 12,
   parameter logic [7:0] LEADER_VAL = 8'o200
) (
   input  logic              clk,
   input  logic              btnCpuReset,
   input  logic              latch_hi,
   input  logic              latch_lo,
   input  logic [7:0]        frame,
   output logic              is_leader,
   output logic              is_marked,
   output logic              lo_bad,
   output logic [WORD_W-1:0] word,
   output logic              origin,
   output logic [WORD_W-1:0] pair_sum,
   output logic [WORD_W-1:0] sum
);

   logic [7:0]        hi_q, hi_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [WORD_W-1:0] pair_q, pair_d;
   logic [WORD_W-1:0] sum_q, sum_d;
   logic              origin_q, origin_d;
   logic [WORD_W-1:0] pair_new;

   assign is_leader = (frame == LEADER_VAL);
   assign is_marked = frame[7];
   assign lo_bad    = frame[7] | frame[6];
   assign pair_new  = WORD_W'(hi_q) + WORD_W'(frame);

   always_comb begin
      hi_d     = hi_q;
      word_d   = word_q;
      pair_d   = pair_q;
      sum_d    = sum_q;
      origin_d = origin_q;
      if (latch_hi) hi_d = frame;
      if (latch_lo) begin
         word_d   = WORD_W'({hi_q[5:0], frame[5:0]});
         origin_d = hi_q[ORIGIN_BIT];
         pair_d   = pair_new;
         sum_d    = sum_q + pair_new;
      end
   end

   always_ff @(posedge clk) begin
      if (!btnCpuReset) begin
         hi_q     <= '0;
         word_q   <= '0;
         pair_q   <= '0;
         sum_q    <= '0;
         origin_q <= 1'b0;
      end else begin
         hi_q     <= hi_d;
         word_q   <= word_d;
         pair_q   <= pair_d;
         sum_q    <= sum_d;
         origin_q <= origin_d;
      end
   end

   assign word     = word_q;
   assign origin   = origin_q;
   assign pair_sum = pair_q;
   assign sum      = sum_q;

endmodule

// File: rtl/pal_tape_loader.sv
// PAL binary tape loader: decodes the frame stream and writes words into PDP-8 memory.
// Optional checksum compare is built when PAL_CHECKSUM_EN is defined.
//
// state  | meaning
// LEADER | skipping leader, waiting for first high frame
// HIGH   | waiting for next high frame or trailer
// LOW    | waiting for low frame of the current pair
// COMMIT | decide whether the pended word must be written first
// WRITE  | memory write outstanding until mem_finished
// FINISH | trailer seen, pended word is the checksum
// DONE   | load complete, terminal
// ERROR  | malformed stream, terminal
module pal_tape_loader #(
   parameter int                WORD_W      = 12,
   parameter logic [WORD_W-1:0] START_PC    = 12'o0200,
   parameter logic [7:0]        LEADER_BYTE = 8'o200
) (
   input  logic              clk,
   input  logic              btnCpuReset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_write_enable,
   output logic [WORD_W-1:0] mem_address,
   output logic [WORD_W-1:0] mem_write_data,
   input  logic              mem_finished,
   output logic              load_done,
   output logic [WORD_W-1:0] start_pc,
   output logic              format_err,
   output logic              checksum_err
);

   import pal_tape_loader_pkg::*;

   loader_state_t     state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              mem_we_q, mem_we_d;
   logic [WORD_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              load_done_q, load_done_d;
   logic [WORD_W-1:0] start_pc_q, start_pc_d;
   logic              format_err_q, format_err_d;
   logic [WORD_W-1:0] pend_word_q, pend_word_d;
   logic [WORD_W-1:0] pend_bytes_q, pend_bytes_d;
   logic              pend_valid_q, pend_valid_d;

   logic              fire, latch_hi, latch_lo, apply;
   logic              is_leader, is_marked, lo_bad, origin;
   logic [WORD_W-1:0] word, pair_sum, sum;

   assign fire = in_valid & in_ready_q;

   pal_frame_assembler #(
      .WORD_W     (WORD_W),
      .LEADER_VAL (LEADER_BYTE)
   ) u_asm (
      .clk         (clk),
      .btnCpuReset (btnCpuReset),
      .latch_hi    (latch_hi),
      .latch_lo    (latch_lo),
      .frame       (in_data),
      .is_leader   (is_leader),
      .is_marked   (is_marked),
      .lo_bad      (lo_bad),
      .word        (word),
      .origin      (origin),
      .pair_sum    (pair_sum),
      .sum         (sum)
   );

`ifdef PAL_CHECKSUM_EN
   logic checksum_err_q, checksum_err_d;
`else
   logic unused_sum;
   assign unused_sum = ^{sum, pend_bytes_q};
`endif

   always_comb begin
      state_d      = state_q;
      mem_we_d     = mem_we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      load_done_d  = load_done_q;
      start_pc_d   = start_pc_q;
      format_err_d = format_err_q;
      pend_word_d  = pend_word_q;
      pend_bytes_d = pend_bytes_q;
      pend_valid_d = pend_valid_q;
      latch_hi     = 1'b0;
      latch_lo     = 1'b0;
      apply        = 1'b0;
`ifdef PAL_CHECKSUM_EN
      checksum_err_d = checksum_err_q;
`endif
      case (state_q)
         LEADER: if (fire && !is_marked) begin
            latch_hi = 1'b1;
            state_d  = LOW;
         end
         HIGH: if (fire) begin
            if (is_leader) state_d = FINISH;
            else if (!is_marked) begin
               latch_hi = 1'b1;
               state_d  = LOW;
            end
         end
         LOW: if (fire) begin
            if (lo_bad) begin
               format_err_d = 1'b1;
               state_d      = ERROR;
            end else begin
               latch_lo = 1'b1;
               state_d  = COMMIT;
            end
         end
         COMMIT: if (pend_valid_q) begin
            mem_we_d = 1'b1;
            wdata_d  = pend_word_q;
            state_d  = WRITE;
         end else apply = 1'b1;
         WRITE: if (mem_finished) begin
            mem_we_d     = 1'b0;
            addr_d       = addr_q + WORD_W'(1);
            pend_valid_d = 1'b0;
            apply        = 1'b1;
         end
         FINISH: if (!pend_valid_q) begin
            format_err_d = 1'b1;
            state_d      = ERROR;
         end else begin
`ifdef PAL_CHECKSUM_EN
            // the checksum pair itself went into sum; take it back out
            if (pend_word_q != sum - pend_bytes_q) checksum_err_d = 1'b1;
`endif
            load_done_d = 1'b1;
            start_pc_d  = START_PC;
            state_d     = DONE;
         end
         default: ;
      endcase
      if (apply) begin
         if (origin) addr_d = word;
         else begin
            pend_word_d  = word;
            pend_bytes_d = pair_sum;
            pend_valid_d = 1'b1;
         end
         state_d = HIGH;
      end
      in_ready_d = (state_d == LEADER) || (state_d == HIGH) || (state_d == LOW);
   end

   always_ff @(posedge clk) begin
      if (!btnCpuReset) begin
         state_q      <= LEADER;
         in_ready_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         load_done_q  <= 1'b0;
         start_pc_q   <= '0;
         format_err_q <= 1'b0;
         pend_word_q  <= '0;
         pend_bytes_q <= '0;
         pend_valid_q <= 1'b0;
`ifdef PAL_CHECKSUM_EN
         checksum_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         mem_we_q     <= mem_we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         load_done_q  <= load_done_d;
         start_pc_q   <= start_pc_d;
         format_err_q <= format_err_d;
         pend_word_q  <= pend_word_d;
         pend_bytes_q <= pend_bytes_d;
         pend_valid_q <= pend_valid_d;
`ifdef PAL_CHECKSUM_EN
         checksum_err_q <= checksum_err_d;
`endif
      end
   end

   assign in_ready         = in_ready_q;
   assign mem_write_enable = mem_we_q;
   assign mem_address      = addr_q;
   assign mem_write_data   = wdata_q;
   assign load_done        = load_done_q;
   assign start_pc         = start_pc_q;
   assign format_err       = format_err_q;
`ifdef PAL_CHECKSUM_EN
   assign checksum_err     = checksum_err_q;
`else
   assign checksum_err     = 1'b0;
`endif

endmodule

// File: tb/tb_pal_tape_loader.sv
// Directed bench for pal_tape_loader with a 3-cycle memory responder.
module tb_pal_tape_loader;

   logic        clk = 1'b0;
   logic        btnCpuReset = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        mem_write_enable;
   logic [11:0] mem_address;
   logic [11:0] mem_write_data;
   logic        mem_finished;
   logic        load_done;
   logic [11:0] start_pc;
   logic        format_err;
   logic        checksum_err;

   logic        resp_fin = 1'b0;
   logic        man_fin = 1'b0;
   bit          resp_en = 1'b1;
   logic [11:0] wr_addr[$];
   logic [11:0] wr_data[$];
   int          n_checks = 0;
   int          n_errs = 0;

`ifdef PAL_CHECKSUM_EN
   localparam logic CK_EN = 1'b1;
`else
   localparam logic CK_EN = 1'b0;
`endif

   assign mem_finished = resp_fin | man_fin;

   always #5 clk = ~clk;

   pal_tape_loader dut (
      .clk              (clk),
      .btnCpuReset      (btnCpuReset),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .in_ready         (in_ready),
      .mem_write_enable (mem_write_enable),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_finished     (mem_finished),
      .load_done        (load_done),
      .start_pc         (start_pc),
      .format_err       (format_err),
      .checksum_err     (checksum_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0o expected %0o", tag, got, exp);
      end
   endtask

   // memory model: record each request, answer 3 cycles later
   initial begin
      forever begin
         @(negedge clk);
         if (mem_write_enable === 1'b1 && resp_en) begin
            wr_addr.push_back(mem_address);
            wr_data.push_back(mem_write_data);
            repeat (2) @(negedge clk);
            resp_fin = 1'b1;
            @(negedge clk);
            resp_fin = 1'b0;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      btnCpuReset = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      btnCpuReset = 1'b1;
      @(negedge clk);
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic send_frame(input logic [7:0] b);
      int n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         chk("ready_timeout", {31'd0, in_ready}, 1);
         return;
      end
      in_valid = 1'b1;
      in_data = b;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_seq(input logic [7:0] s[$]);
      foreach (s[i]) send_frame(s[i]);
   endtask

   task automatic wait_end(input string tag);
      int n = 0;
      while (load_done !== 1'b1 && format_err !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, load_done | format_err}, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_two_writes(input string tag, input logic [11:0] a0, input logic [11:0] d0,
                                   input logic [11:0] a1, input logic [11:0] d1);
      chk({tag, "_nwr"}, wr_addr.size(), 2);
      if (wr_addr.size() == 2) begin
         chk({tag, "_a0"}, {20'd0, wr_addr[0]}, {20'd0, a0});
         chk({tag, "_d0"}, {20'd0, wr_data[0]}, {20'd0, d0});
         chk({tag, "_a1"}, {20'd0, wr_addr[1]}, {20'd0, a1});
         chk({tag, "_d1"}, {20'd0, wr_data[1]}, {20'd0, d1});
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] s[$];
      int n;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, in_ready}, 0);
      chk("rst_we", {31'd0, mem_write_enable}, 0);
      chk("rst_addr", {20'd0, mem_address}, 0);
      chk("rst_wdata", {20'd0, mem_write_data}, 0);
      chk("rst_done", {31'd0, load_done}, 0);
      chk("rst_pc", {20'd0, start_pc}, 0);
      chk("rst_ferr", {31'd0, format_err}, 0);
      chk("rst_cerr", {31'd0, checksum_err}, 0);
      btnCpuReset = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, in_ready}, 1);

      // basic load, good checksum 0325
      s = '{8'o200, 8'o200, 8'o200, 8'o102, 8'o000, 8'o012, 8'o034,
            8'o056, 8'o077, 8'o003, 8'o025, 8'o200};
      send_seq(s);
      wait_end("t1_end");
      check_two_writes("t1", 12'o0200, 12'o1234, 12'o0201, 12'o5677);
      chk("t1_done", {31'd0, load_done}, 1);
      chk("t1_pc", {20'd0, start_pc}, 12'o0200);
      chk("t1_ferr", {31'd0, format_err}, 0);
      chk("t1_cerr", {31'd0, checksum_err}, 0);
      chk("t1_ready", {31'd0, in_ready}, 0);
      chk("t1_addr", {20'd0, mem_address}, 12'o0202);

      // bad checksum 0326
      do_reset();
      s = '{8'o200, 8'o200, 8'o200, 8'o102, 8'o000, 8'o012, 8'o034,
            8'o056, 8'o077, 8'o003, 8'o026, 8'o200};
      send_seq(s);
      wait_end("t2_end");
      chk("t2_done", {31'd0, load_done}, 1);
      chk("t2_cerr", {31'd0, checksum_err}, {31'd0, CK_EN});
      chk("t2_ferr", {31'd0, format_err}, 0);
      chk("t2_nwr", wr_addr.size(), 2);

      // address wrap 7777 -> 0000, checksum 0301
      do_reset();
      s = '{8'o200, 8'o177, 8'o077, 8'o000, 8'o001, 8'o000, 8'o002,
            8'o003, 8'o001, 8'o200};
      send_seq(s);
      wait_end("t3_end");
      check_two_writes("t3", 12'o7777, 12'o0001, 12'o0000, 12'o0002);
      chk("t3_done", {31'd0, load_done}, 1);
      chk("t3_cerr", {31'd0, checksum_err}, 0);

      // trailer with no checksum word pending
      do_reset();
      s = '{8'o200, 8'o200, 8'o102, 8'o000, 8'o200};
      send_seq(s);
      wait_end("t4_end");
      chk("t4_ferr", {31'd0, format_err}, 1);
      chk("t4_nwr", wr_addr.size(), 0);
      chk("t4_ready", {31'd0, in_ready}, 0);
      chk("t4_done", {31'd0, load_done}, 0);
      chk("t4_pc", {20'd0, start_pc}, 0);

      // bad low frame 100 after high 012
      do_reset();
      s = '{8'o200, 8'o102, 8'o000, 8'o012, 8'o034, 8'o012, 8'o100};
      send_seq(s);
      wait_end("t5_end");
      chk("t5_ferr", {31'd0, format_err}, 1);
      chk("t5_ready", {31'd0, in_ready}, 0);
      chk("t5_we", {31'd0, mem_write_enable}, 0);
      chk("t5_nwr", wr_addr.size(), 0);

      // reset while a write waits on mem_finished
      do_reset();
      resp_en = 1'b0;
      s = '{8'o200, 8'o102, 8'o000, 8'o012, 8'o034, 8'o056, 8'o077};
      send_seq(s);
      n = 0;
      while (mem_write_enable !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t6_we_up", {31'd0, mem_write_enable}, 1);
      repeat (3) @(negedge clk);
      chk("t6_we_hold", {31'd0, mem_write_enable}, 1);
      chk("t6_addr_hold", {20'd0, mem_address}, 12'o0200);
      chk("t6_data_hold", {20'd0, mem_write_data}, 12'o1234);
      btnCpuReset = 1'b0;
      @(negedge clk);
      chk("t6_we_rst", {31'd0, mem_write_enable}, 0);
      chk("t6_addr_rst", {20'd0, mem_address}, 0);
      chk("t6_wdata_rst", {20'd0, mem_write_data}, 0);
      chk("t6_ready_rst", {31'd0, in_ready}, 0);
      btnCpuReset = 1'b1;
      @(negedge clk);
      man_fin = 1'b1;
      @(negedge clk);
      man_fin = 1'b0;
      chk("t6_we_idle", {31'd0, mem_write_enable}, 0);
      chk("t6_addr_idle", {20'd0, mem_address}, 0);
      resp_en = 1'b1;
      wr_addr.delete();
      wr_data.delete();
      s = '{8'o200, 8'o102, 8'o000, 8'o012, 8'o034,
            8'o056, 8'o077, 8'o003, 8'o025, 8'o200};
      send_seq(s);
      wait_end("t6_end");
      check_two_writes("t6", 12'o0200, 12'o1234, 12'o0201, 12'o5677);
      chk("t6_done", {31'd0, load_done}, 1);
      chk("t6_ferr", {31'd0, format_err}, 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
